// File: rtl/obuft_pkg.sv
// Shared types and helpers for the registered tri-state output bank.
// Holds the turnaround FSM state encoding and a constant log2 helper.
package obuft_pkg;

    localparam int OBUFT_MAX_TURN = 255;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        DRIVE,
        GUARD
    } obuft_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((64'd1 << k) < 64'(value)) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/obuft_turn_fsm.sv
// Bus-turnaround controller: dead cycles before taking and after releasing the bus.
// GTS forces release on the next edge; CLR releases asynchronously with no guard interval.
module obuft_turn_fsm
    import obuft_pkg::*;
#(
    parameter int TURN_CYC = 2
) (
    input  logic C,
    input  logic CLR,
    input  logic GTS,
    input  logic OE_REQ,
    output logic t_q,
    output logic busy
);

    localparam int CW = (clog2(TURN_CYC + 1) < 1) ? 1 : clog2(TURN_CYC + 1);
    localparam logic [CW-1:0] RELOAD = (TURN_CYC == 0) ? '0 : CW'(TURN_CYC - 1);

    obuft_state_t    state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            t_d;

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            t_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        if (GTS) begin
            state_d = IDLE;
            cnt_d   = '0;
            t_d     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (OE_REQ) begin
                        if (TURN_CYC == 0) begin
                            state_d = DRIVE;
                            t_d     = 1'b0;
                        end else begin
                            state_d = ARM;
                            cnt_d   = RELOAD;
                        end
                    end
                end
                ARM: begin
                    // Dropping the request here aborts before the bus is ever driven.
                    if (!OE_REQ) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = DRIVE;
                        t_d     = 1'b0;
                    end
                end
                DRIVE: begin
                    if (!OE_REQ) begin
                        t_d = 1'b1;
                        if (TURN_CYC == 0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = GUARD;
                            cnt_d   = RELOAD;
                        end
                    end
                end
                GUARD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    t_d     = 1'b1;
                end
            endcase
        end
    end

    assign busy = (state_q == ARM) || (state_q == GUARD);

endmodule

// File: rtl/obuft_bank_reg.sv
// Registered WIDTH-bit tri-state pad bank; data lags I by one edge.
// GTS forces the pads to hi-Z combinationally, independent of the clock.
module obuft_bank_reg
    import obuft_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               TURN_CYC = 2,
    parameter logic [WIDTH-1:0] INIT     = '0
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             GTS,
    input  logic [WIDTH-1:0] I,
    input  logic             OE_REQ,
    output tri   [WIDTH-1:0] O,
    output logic             DRIVING,
    output logic             BUSY
);

    logic [WIDTH-1:0] i_q;
    logic             t_q;

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            i_q <= INIT;
        end else begin
            i_q <= I;
        end
    end

    obuft_turn_fsm #(
        .TURN_CYC (TURN_CYC)
    ) u_fsm (
        .C      (C),
        .CLR    (CLR),
        .GTS    (GTS),
        .OE_REQ (OE_REQ),
        .t_q    (t_q),
        .busy   (BUSY)
    );

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign O[g] = (t_q | GTS) ? 1'bz : i_q[g];
    end

    assign DRIVING = ~t_q;

endmodule

// File: tb/tb_obuft_bank_reg.sv
// Bench for obuft_bank_reg: each configuration is built twice, once on a pulled-up
// and once on a pulled-down pad net, so hi-Z is seen as the two copies disagreeing.
module tb_obuft_bank_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic       gts0, oe0, gts1, oe1, gts2, oe2;
    logic [7:0] i0, i1;
    logic [0:0] i2;

    tri1 [7:0] o0u, o1u;
    tri0 [7:0] o0d, o1d;
    tri1 [0:0] o2u;
    tri0 [0:0] o2d;

    logic drv0, busy0, drv0x, busy0x;
    logic drv1, busy1, drv1x, busy1x;
    logic drv2, busy2, drv2x, busy2x;

    obuft_bank_reg #(.WIDTH(8), .TURN_CYC(2), .INIT(8'hA5)) u0u (.C(clk), .CLR(clr), .GTS(gts0),
        .I(i0), .OE_REQ(oe0), .O(o0u), .DRIVING(drv0), .BUSY(busy0));
    obuft_bank_reg #(.WIDTH(8), .TURN_CYC(2), .INIT(8'hA5)) u0d (.C(clk), .CLR(clr), .GTS(gts0),
        .I(i0), .OE_REQ(oe0), .O(o0d), .DRIVING(drv0x), .BUSY(busy0x));
    obuft_bank_reg #(.WIDTH(8), .TURN_CYC(3)) u1u (.C(clk), .CLR(clr), .GTS(gts1),
        .I(i1), .OE_REQ(oe1), .O(o1u), .DRIVING(drv1), .BUSY(busy1));
    obuft_bank_reg #(.WIDTH(8), .TURN_CYC(3)) u1d (.C(clk), .CLR(clr), .GTS(gts1),
        .I(i1), .OE_REQ(oe1), .O(o1d), .DRIVING(drv1x), .BUSY(busy1x));
    obuft_bank_reg #(.WIDTH(1), .TURN_CYC(0)) u2u (.C(clk), .CLR(clr), .GTS(gts2),
        .I(i2), .OE_REQ(oe2), .O(o2u), .DRIVING(drv2), .BUSY(busy2));
    obuft_bank_reg #(.WIDTH(1), .TURN_CYC(0)) u2d (.C(clk), .CLR(clr), .GTS(gts2),
        .I(i2), .OE_REQ(oe2), .O(o2d), .DRIVING(drv2x), .BUSY(busy2x));

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       oe;
        logic [7:0] i;
        logic       e_drv;
        logic       e_busy;
        logic       e_z;
        logic [7:0] e_o;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_pad(input string nm, input logic [7:0] up, input logic [7:0] dn,
                           input logic ez, input logic [7:0] ev, input logic [7:0] mask);
        logic ok;
        n_chk++;
        if (ez) ok = ((up & mask) == mask) && ((dn & mask) == 8'h00);
        else    ok = ((up & mask) == (ev & mask)) && ((dn & mask) == (ev & mask));
        if (!ok) begin
            n_fail++;
            if (ez) $display("FAIL %s: pad pulled-up=%h pulled-down=%h expected hi-Z", nm, up, dn);
            else    $display("FAIL %s: pad pulled-up=%h pulled-down=%h expected %h", nm, up, dn, ev & mask);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       m_drv;
        int         m_run;
        int         m_elig;
        logic [7:0] m_iq;
        logic       m_busy;

        clr = 1'b1;
        gts0 = 0; oe0 = 0; i0 = 8'h00;
        gts1 = 0; oe1 = 0; i1 = 8'hFF;
        gts2 = 0; oe2 = 0; i2 = 1'b0;

        tbl[0] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[2] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};
        tbl[3] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A};
        tbl[4] = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[5] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[6] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[7] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[8] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[9] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 8'h66};

        // Reset state
        #3;
        chk_pad("reset_pad", o0u, o0d, 1'b1, 8'h00, 8'hFF);
        chk("reset_driving", 64'(drv0), 64'd0);
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_iq", 64'(u0u.i_q), 64'hA5);
        @(negedge clk);
        clr = 1'b0;

        // Turn-on, release, guard and re-arm with TURN_CYC=2
        for (int k = 0; k < 10; k++) begin
            oe0 = tbl[k].oe;
            i0  = tbl[k].i;
            step();
            chk($sformatf("tbl%0d_driving", k), 64'(drv0), 64'(tbl[k].e_drv));
            chk($sformatf("tbl%0d_busy", k), 64'(busy0), 64'(tbl[k].e_busy));
            chk_pad($sformatf("tbl%0d_pad", k), o0u, o0d, tbl[k].e_z, tbl[k].e_o, 8'hFF);
        end

        // Asynchronous reset while driving: immediate release, no guard
        #3;
        clr = 1'b1;
        #1;
        chk_pad("clr_mid_drive_pad", o0u, o0d, 1'b1, 8'h00, 8'hFF);
        chk("clr_mid_drive_driving", 64'(drv0), 64'd0);
        chk("clr_mid_drive_busy", 64'(busy0), 64'd0);
        chk("clr_mid_drive_iq", 64'(u0u.i_q), 64'hA5);
        oe0 = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        step();
        chk("after_clr_busy", 64'(busy0), 64'd0);
        chk_pad("after_clr_pad", o0u, o0d, 1'b1, 8'h00, 8'hFF);

        // Abort in ARM with TURN_CYC=3
        oe1 = 1'b1;
        step();
        chk("abort_arm_busy", 64'(busy1), 64'd1);
        chk_pad("abort_arm_pad", o1u, o1d, 1'b1, 8'h00, 8'hFF);
        oe1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("abort_idle%0d_busy", k), 64'(busy1), 64'd0);
            chk($sformatf("abort_idle%0d_driving", k), 64'(drv1), 64'd0);
            chk_pad($sformatf("abort_idle%0d_pad", k), o1u, o1d, 1'b1, 8'h00, 8'hFF);
        end

        // GTS during DRIVE, then a full re-arm
        oe0 = 1'b1;
        i0  = 8'h96;
        repeat (3) step();
        chk_pad("gts_pre_pad", o0u, o0d, 1'b0, 8'h96, 8'hFF);
        #2;
        gts0 = 1'b1;
        #1;
        chk_pad("gts_async_pad", o0u, o0d, 1'b1, 8'h00, 8'hFF);
        step();
        chk("gts_edge_driving", 64'(drv0), 64'd0);
        chk("gts_edge_busy", 64'(busy0), 64'd0);
        step();
        chk("gts_hold_busy", 64'(busy0), 64'd0);
        gts0 = 1'b0;
        step();
        chk("gts_rearm0_busy", 64'(busy0), 64'd1);
        chk_pad("gts_rearm0_pad", o0u, o0d, 1'b1, 8'h00, 8'hFF);
        step();
        chk("gts_rearm1_busy", 64'(busy0), 64'd1);
        step();
        chk("gts_redrive_driving", 64'(drv0), 64'd1);
        chk_pad("gts_redrive_pad", o0u, o0d, 1'b0, 8'h96, 8'hFF);

        // TURN_CYC=0, WIDTH=1: toggle request every cycle
        for (int k = 0; k < 8; k++) begin
            oe2 = ~k[0];
            i2  = 1'($urandom);
            step();
            chk($sformatf("t0_%0d_driving", k), 64'(drv2), 64'(oe2));
            chk($sformatf("t0_%0d_busy", k), 64'(busy2), 64'd0);
            chk_pad($sformatf("t0_%0d_pad", k), 8'(o2u), 8'(o2d), ~oe2, 8'(i2), 8'h01);
        end

        // Random traffic on TURN_CYC=2 against a timing-rule model
        oe0 = 1'b0; gts0 = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_drv = 1'b0; m_run = 0; m_elig = 0; m_iq = 8'hA5;
        for (int e = 0; e < 400; e++) begin
            if ($urandom_range(3) == 0) oe0 = ~oe0;
            gts0 = ($urandom_range(11) == 0);
            i0   = 8'($urandom);
            step();
            m_iq = i0;
            if (gts0) begin
                m_drv = 1'b0; m_run = 0; m_elig = e + 1;
            end else if (m_drv) begin
                if (!oe0) begin
                    m_drv  = 1'b0;
                    m_elig = e + 2 + 1;
                end
            end else if (e >= m_elig && oe0) begin
                m_run++;
                if (m_run == 2 + 1) begin
                    m_drv = 1'b1; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_busy = !m_drv && (m_run > 0 || e + 1 < m_elig);
            chk($sformatf("rnd%0d_driving", e), 64'(drv0), 64'(m_drv));
            chk($sformatf("rnd%0d_busy", e), 64'(busy0), 64'(m_busy));
            chk_pad($sformatf("rnd%0d_pad", e), o0u, o0d, !m_drv || gts0, m_iq, 8'hFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
